// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, feeding a first-word-fall-through FIFO.
// Bad stop bits pulse frame_err; bytes arriving while the FIFO is full pulse overrun.
module uart_rx_fifo #(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned BAUD_DIV = 163,
  parameter int unsigned FIFO_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            overrun,
  output logic            frame_err
);

  localparam int unsigned CntW  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int unsigned Depth = 2 ** FIFO_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic            rx_meta_q, rxs_q;
  logic [CntW-1:0] cnt_q;
  logic            tick;
  logic [1:0]      state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            push;

  logic [FIFO_W:0] wr_ptr_q, rd_ptr_q;
  logic [DBIT-1:0] mem_q [Depth];
  logic            pop, push_ok;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign tick = (cnt_q == CntW'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == 4'd7) begin
            if (!rxs_q) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            shift_d = {rxs_q, shift_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = StStop;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            state_d = StIdle;
            if (rxs_q) begin
              push = 1'b1;
            end else begin
              frame_err = 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign rx_empty = (wr_ptr_q == rd_ptr_q);
  assign rx_full  = (wr_ptr_q[FIFO_W] != rd_ptr_q[FIFO_W]) &&
                    (wr_ptr_q[FIFO_W-1:0] == rd_ptr_q[FIFO_W-1:0]);
  assign pop      = rd_uart && !rx_empty;
  assign push_ok  = push && (!rx_full || pop);
  assign overrun  = push && rx_full && !pop;
  assign r_data   = mem_q[rd_ptr_q[FIFO_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[FIFO_W-1:0]] <= shift_q;
        wr_ptr_q                    <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned BitCyc = 32;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rd_uart;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rx_full;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx_fifo #(
    .DBIT    (8),
    .SB_TICK (16),
    .BAUD_DIV(2),
    .FIFO_W  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rd_uart  (rd_uart),
    .r_data   (r_data),
    .rx_empty (rx_empty),
    .rx_full  (rx_full),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every high cycle counts, so a pulse wider than one cycle shows up as >1.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_fe;
    logic       exp_empty;
    logic [7:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Callers are always at posedge+1 when these are entered.
  task automatic drive_bit(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0, BitCyc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BitCyc);
    if (stop) begin
      drive_bit(1'b1, BitCyc);
    end else begin
      // Low across the stop sample point, high early enough that the trailing
      // low is rejected as a glitch rather than read as a new start bit.
      drive_bit(1'b0, 24);
      drive_bit(1'b1, 40);
    end
  endtask

  task automatic do_pop();
    rd_uart = 1'b1;
    @(posedge clk);
    #1;
    rd_uart = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t       vecs[4];
  logic [7:0] q[$];

  initial begin
    int fe0;
    int ov0;
    logic [7:0] d;
    logic stop;
    int npops;

    vecs[0] = '{data: 8'h01, stop: 1'b1, exp_fe: 0, exp_empty: 1'b0, exp_data: 8'h01};
    vecs[1] = '{data: 8'h5A, stop: 1'b1, exp_fe: 0, exp_empty: 1'b0, exp_data: 8'h5A};
    vecs[2] = '{data: 8'hA5, stop: 1'b0, exp_fe: 1, exp_empty: 1'b1, exp_data: 8'h00};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_fe: 0, exp_empty: 1'b0, exp_data: 8'hFF};

    reset   = 1'b0;
    rx      = 1'b1;
    rd_uart = 1'b0;
    wait_cyc(10);
    check("rst_empty", 32'(rx_empty), 32'd1);
    check("rst_full", 32'(rx_full), 32'd0);
    check("rst_rdata", 32'(r_data), 32'h00);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b1;
    wait_cyc(200);
    check("idle_empty", 32'(rx_empty), 32'd1);

    // Short low pulse on the line: must be rejected in the start state.
    fe0 = fe_cnt;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 80);
    check("glitch_empty", 32'(rx_empty), 32'd1);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

    for (int i = 0; i < 4; i++) begin
      fe0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d_fe", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_empty", i), 32'(rx_empty), 32'(vecs[i].exp_empty));
      if (!vecs[i].exp_empty) begin
        check($sformatf("vec%0d_data", i), 32'(r_data), 32'(vecs[i].exp_data));
        do_pop();
        check($sformatf("vec%0d_pop_empty", i), 32'(rx_empty), 32'd1);
      end
    end

    // Fill past capacity without reading.
    ov0 = ov_cnt;
    for (int k = 0; k < 5; k++) begin
      send_frame(8'(8'h10 + k), 1'b1);
      if (k == 2) check("fill_not_full", 32'(rx_full), 32'd0);
      if (k == 3) begin
        check("fill_full", 32'(rx_full), 32'd1);
        check("fill_no_ov_yet", 32'(ov_cnt - ov0), 32'd0);
      end
    end
    check("overrun_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("full_after_ov", 32'(rx_full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_data", k), 32'(r_data), 32'(8'h10 + k));
      check($sformatf("drain%0d_not_empty", k), 32'(rx_empty), 32'd0);
      do_pop();
    end
    check("drain_empty", 32'(rx_empty), 32'd1);
    check("drain_not_full", 32'(rx_full), 32'd0);

    // Reset in the middle of data bit 3 of 0x77.
    drive_bit(1'b0, BitCyc);
    drive_bit(1'b1, BitCyc);
    drive_bit(1'b1, BitCyc);
    drive_bit(1'b1, BitCyc);
    drive_bit(1'b0, BitCyc / 2);
    reset = 1'b0;
    rx    = 1'b1;
    wait_cyc(5);
    check("midrst_empty", 32'(rx_empty), 32'd1);
    check("midrst_full", 32'(rx_full), 32'd0);
    check("midrst_rdata", 32'(r_data), 32'h00);
    reset = 1'b1;
    wait_cyc(50);
    check("postrst_empty", 32'(rx_empty), 32'd1);
    send_frame(8'h3C, 1'b1);
    check("postrst_data", 32'(r_data), 32'h3C);
    do_pop();
    check("postrst_single", 32'(rx_empty), 32'd1);

    // Randomized frames and reads against a byte-queue reference.
    q.delete();
    for (int it = 0; it < 16; it++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      fe0  = fe_cnt;
      ov0  = ov_cnt;
      send_frame(d, stop);
      check($sformatf("rnd%0d_fe", it), 32'(fe_cnt - fe0), 32'(!stop));
      check($sformatf("rnd%0d_ov", it), 32'(ov_cnt - ov0), 32'(stop && q.size() == 4));
      if (stop && q.size() < 4) q.push_back(d);
      check($sformatf("rnd%0d_empty", it), 32'(rx_empty), 32'(q.size() == 0));
      check($sformatf("rnd%0d_full", it), 32'(rx_full), 32'(q.size() == 4));
      npops = $urandom_range(0, 3);
      for (int p = 0; p < npops; p++) begin
        if (q.size() > 0) begin
          check($sformatf("rnd%0d_pop%0d", it, p), 32'(r_data), 32'(q[0]));
          void'(q.pop_front());
        end
        do_pop();
      end
      check($sformatf("rnd%0d_empty_after", it), 32'(rx_empty), 32'(q.size() == 0));
      wait_cyc($urandom_range(0, 20));
    end
    while (q.size() > 0) begin
      check("final_drain", 32'(r_data), 32'(q[0]));
      void'(q.pop_front());
      do_pop();
    end
    check("final_empty", 32'(rx_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
